// File: rtl/dither_ctrl_pkg.sv
// Shared definitions for the dither lock-in controller.
//  - dli_state_e : modulation sequencer states
//  - LOCK_COUNT  : consecutive good updates needed to declare lock
//  - sat_clip    : clip a signed value into a w-bit signed range
package dither_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, POS, NEG, UPDATE} dli_state_e;

  localparam int LOCK_COUNT = 4;

  function automatic logic signed [63:0] sat_clip(input logic signed [63:0] v,
                                                  input int w);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/dli_sat_add.sv
// Signed saturating adder.
//  a, b : W-bit signed operands
//  y    : OW-bit signed sum, clipped into the OW-bit range
//  s    : 1 when the sum was clipped
module dli_sat_add
  import dither_ctrl_pkg::*;
#(
  parameter int W  = 42,
  parameter int OW = 25
) (
  input  logic signed [W-1:0]  a,
  input  logic signed [W-1:0]  b,
  output logic signed [OW-1:0] y,
  output logic                 s
);

  logic signed [W:0]  sum;
  logic signed [63:0] wide, clip;

  // one extra bit so the raw sum itself can never wrap
  assign sum  = (W+1)'(a) + (W+1)'(b);
  assign wide = 64'(sum);
  assign clip = sat_clip(wide, OW);
  assign y    = OW'(clip);
  assign s    = (clip != wide);

endmodule

// File: rtl/dither_lockin_ctrl.sv
// Dither lock-in controller: square-wave modulation, synchronous
// demodulation of err_in and integration into a dynamic offset.
//  clk, rst_n    : clock, synchronous active-low reset
//  enable, clear : run loop / zero offset+accumulator (pulse)
//  half_period, settle, mod_amp, gain_shift : per-period config,
//                  latched on loop start and at every update
//  lock_thresh   : |step| lock threshold
//  err_in        : error from scaler
//  mod, DITHon   : modulation and dither enable to scaler
//  offset, upd_stb, sat, locked : integrator output and status
// Optional feature: define DLI_LOCK_DETECT_EN for the lock detector;
// otherwise locked is tied low.
module dither_lockin_ctrl
  import dither_ctrl_pkg::*;
#(
  parameter int N_B         = 16,
  parameter int SIGNAL_SIZE = 25,
  parameter int N_HP        = 16,
  parameter int N_ACC       = 42
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          clear,
  input  logic [N_HP-1:0]               half_period,
  input  logic [N_HP-1:0]               settle,
  input  logic signed [N_B-1:0]         mod_amp,
  input  logic [4:0]                    gain_shift,
  input  logic [SIGNAL_SIZE-1:0]        lock_thresh,
  input  logic signed [SIGNAL_SIZE-1:0] err_in,
  output logic signed [N_B-1:0]         mod,
  output logic                          DITHon,
  output logic signed [SIGNAL_SIZE-1:0] offset,
  output logic                          upd_stb,
  output logic                          sat,
  output logic                          locked
);

  dli_state_e st, st_nxt;
  logic [N_HP-1:0]              cnt, hp_q, settle_q;
  logic signed [N_B-1:0]        amp_q, amp_nxt, mod_nxt;
  logic [4:0]                   gs_q;
  logic signed [N_ACC-1:0]      acc, step, err_ext;
  logic signed [SIGNAL_SIZE-1:0] off_sum;
  logic                         add_sat, latch, last, sample;

  assign err_ext = N_ACC'(err_in);
  assign step    = acc >>> gs_q;
  assign last    = (cnt == hp_q - N_HP'(1));
  assign sample  = (st == POS || st == NEG) && enable && (cnt >= settle_q);
  assign amp_nxt = latch ? mod_amp : amp_q;

  always_comb begin
    st_nxt = st;
    latch  = 1'b0;
    case (st)
      IDLE:   if (enable) begin st_nxt = POS; latch = 1'b1; end
      POS:    if (!enable) st_nxt = IDLE; else if (last) st_nxt = NEG;
      NEG:    if (!enable) st_nxt = IDLE; else if (last) st_nxt = UPDATE;
      UPDATE: if (enable) begin st_nxt = POS; latch = 1'b1; end
              else st_nxt = IDLE;
      default: st_nxt = IDLE;
    endcase
  end

  // outputs are registered from the next state so they move with it
  always_comb begin
    mod_nxt = -amp_nxt;
    if (st_nxt == IDLE)     mod_nxt = '0;
    else if (st_nxt == POS) mod_nxt = amp_nxt;
  end

  dli_sat_add #(.W(N_ACC), .OW(SIGNAL_SIZE)) u_add (
    .a (N_ACC'(offset)),
    .b (step),
    .y (off_sum),
    .s (add_sat)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st       <= IDLE;
      cnt      <= '0;
      hp_q     <= N_HP'(1);
      settle_q <= '0;
      amp_q    <= '0;
      gs_q     <= '0;
      acc      <= '0;
      mod      <= '0;
      DITHon   <= 1'b0;
      offset   <= '0;
      upd_stb  <= 1'b0;
      sat      <= 1'b0;
    end else begin
      st     <= st_nxt;
      mod    <= mod_nxt;
      DITHon <= (st_nxt != IDLE);
      cnt    <= (latch || st_nxt != st) ? '0 : cnt + N_HP'(1);
      if (latch) begin
        hp_q     <= (half_period == '0) ? N_HP'(1) : half_period;
        settle_q <= settle;
        amp_q    <= mod_amp;
        gs_q     <= gain_shift;
      end
      upd_stb <= 1'b0;
      if (clear) begin
        offset <= '0;
        acc    <= '0;
        sat    <= 1'b0;
      end else if (st == UPDATE) begin
        offset  <= off_sum;
        sat     <= sat | add_sat;
        upd_stb <= 1'b1;
        acc     <= '0;
      end else if (st_nxt == IDLE) begin
        acc <= '0;   // aborted period: discard partial sum
      end else if (sample) begin
        acc <= acc + ((st == POS) ? err_ext : -err_ext);
      end
    end
  end

`ifdef DLI_LOCK_DETECT_EN
  logic [2:0]       lk_cnt;
  logic [N_ACC-1:0] step_mag;
  logic             step_ok;

  assign step_mag = (step < 0) ? N_ACC'(-step) : N_ACC'(step);
  assign step_ok  = (step_mag <= N_ACC'(lock_thresh)) && !add_sat;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lk_cnt <= '0;
      locked <= 1'b0;
    end else if (clear || !enable) begin
      lk_cnt <= '0;
      locked <= 1'b0;
    end else if (st == UPDATE) begin
      if (step_ok) begin
        if (lk_cnt != 3'(LOCK_COUNT)) lk_cnt <= lk_cnt + 3'd1;
        locked <= (lk_cnt >= 3'(LOCK_COUNT - 1));
      end else begin
        lk_cnt <= '0;
        locked <= 1'b0;
      end
    end
  end
`else
  logic unused_thresh;
  assign unused_thresh = ^lock_thresh;
  assign locked        = 1'b0;
`endif

endmodule

// File: tb/tb_dither_lockin_ctrl.sv
// Self-checking bench for dither_lockin_ctrl. A period-position model
// (position p within a 2*hp+1 clock period) predicts every output.
module tb_dither_lockin_ctrl;
  localparam int N_B = 16, SS = 25, N_HP = 16, N_ACC = 42;
  localparam longint OMAX = (64'sd1 <<< (SS - 1)) - 1;
  localparam longint OMIN = -(64'sd1 <<< (SS - 1));
  localparam int EMAX = (1 << (SS - 1)) - 1;

  logic clk = 1'b0;
  logic rst_n, enable, clear;
  logic [N_HP-1:0] half_period, settle;
  logic signed [N_B-1:0] mod_amp;
  logic [4:0] gain_shift;
  logic [SS-1:0] lock_thresh;
  logic signed [SS-1:0] err_in;
  logic signed [N_B-1:0] mod;
  logic DITHon, upd_stb, sat, locked;
  logic signed [SS-1:0] offset;

  always #5 clk = ~clk;

  dither_lockin_ctrl #(.N_B(N_B), .SIGNAL_SIZE(SS), .N_HP(N_HP), .N_ACC(N_ACC)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
    .half_period(half_period), .settle(settle), .mod_amp(mod_amp),
    .gain_shift(gain_shift), .lock_thresh(lock_thresh), .err_in(err_in),
    .mod(mod), .DITHon(DITHon), .offset(offset), .upd_stb(upd_stb),
    .sat(sat), .locked(locked)
  );

  int n_cmp = 0, n_err = 0;
  bit m_run, m_sat, m_upd;
  int m_p, m_hp, m_st, m_amp, m_gs, m_lc, e_const;
  longint m_acc, m_off;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_run = 0; m_p = 0; m_acc = 0; m_off = 0; m_sat = 0; m_upd = 0;
    m_lc = 0; m_hp = 1; m_st = 0; m_amp = 0; m_gs = 0;
  endtask

  task automatic m_latch();
    m_hp  = (half_period == 0) ? 1 : int'(half_period);
    m_st  = int'(settle);
    m_amp = int'(mod_amp);
    m_gs  = int'(gain_shift);
  endtask

  // advance the model over one clock, using the inputs now driven
  task automatic m_step();
    longint stp, s, mag, thr;
    bit clip;
    m_upd = 0;
    if (!rst_n) begin m_reset(); return; end
    if (m_run) begin
      if (m_p < 2 * m_hp) begin
        if (!enable) begin m_run = 0; m_acc = 0; end
        else begin
          if (m_p < m_hp) begin if (m_p >= m_st) m_acc += longint'(err_in); end
          else if (m_p - m_hp >= m_st) m_acc -= longint'(err_in);
          m_p++;
        end
      end else begin
        if (!clear) begin
          stp = m_acc >>> m_gs;
          s = m_off + stp;
          clip = 0;
          if (s > OMAX) begin s = OMAX; clip = 1; end
          if (s < OMIN) begin s = OMIN; clip = 1; end
          if (clip) m_sat = 1;
          m_off = s;
          m_upd = 1;
          mag = (stp < 0) ? -stp : stp;
          thr = longint'(lock_thresh);
          if (mag <= thr && !clip) m_lc = (m_lc < 4) ? m_lc + 1 : 4;
          else m_lc = 0;
        end
        m_acc = 0;
        if (enable) begin m_latch(); m_p = 0; end
        else m_run = 0;
      end
    end else if (enable) begin
      m_latch(); m_run = 1; m_p = 0;
    end
    if (clear) begin m_off = 0; m_acc = 0; m_sat = 0; m_lc = 0; end
    if (!enable) m_lc = 0;
  endtask

  task automatic cyc();
    longint em;
    m_step();
    @(posedge clk); #1;
    em = !m_run ? 0 : (m_p < m_hp) ? longint'(m_amp) : -longint'(m_amp);
    chk("mod", longint'(mod), em);
    chk("DITHon", longint'(DITHon), longint'(m_run));
    chk("offset", longint'(offset), m_off);
    chk("upd_stb", longint'(upd_stb), longint'(m_upd));
    chk("sat", longint'(sat), longint'(m_sat));
`ifdef DLI_LOCK_DETECT_EN
    chk("locked", longint'(locked), longint'(m_lc >= 4));
`else
    chk("locked", longint'(locked), 0);
`endif
  endtask

  task automatic rnd_cfg();
    half_period = N_HP'($urandom_range(0, 10));
    settle      = N_HP'($urandom_range(0, 8));
    mod_amp     = N_B'(int'($urandom_range(0, 65534)) - 32767);
    gain_shift  = 5'($urandom_range(0, 6));
  endtask

  // mode: 0 const, 1 random, 2 +/-5 with modulation, 3 +/-max, 4 -/+max
  task automatic seg(input int hp, input int st, input int amp, input int gs,
                     input int thr, input int mode, input int n, input bit rnd);
    half_period = N_HP'(hp); settle = N_HP'(st); mod_amp = N_B'(amp);
    gain_shift = 5'(gs); lock_thresh = SS'(thr); enable = 1'b1;
    for (int i = 0; i < n; i++) begin
      case (mode)
        0: err_in = SS'(e_const);
        1: err_in = SS'(int'($urandom_range(0, 2 << 20)) - (1 << 20));
        2: err_in = SS'((m_run && m_p < m_hp) ? 5 : -5);
        3: err_in = SS'((m_run && m_p < m_hp) ? EMAX : -EMAX);
        default: err_in = SS'((m_run && m_p < m_hp) ? -EMAX : EMAX);
      endcase
      if (rnd) begin
        clear  = ($urandom_range(0, 39) == 0);
        enable = ($urandom_range(0, 29) != 0);
        if ($urandom_range(0, 9) == 0) rnd_cfg();
      end
      cyc();
      clear = 1'b0;
    end
  endtask

  initial begin
    m_reset();
    rst_n = 0; enable = 0; clear = 0; half_period = 0; settle = 0;
    mod_amp = 0; gain_shift = 0; lock_thresh = 0; err_in = 0; e_const = 0;
    repeat (3) cyc();
    rst_n = 1;
    cyc();
    // square wave, hp=4
    seg(4, 0, 100, 0, 0, 0, 30, 0);
    // constant error cancels, settle skips
    e_const = 10;
    seg(8, 2, 300, 0, 0, 0, 60, 0);
    // integration 20 per period
    enable = 0; clear = 1; cyc(); clear = 0; cyc();
    seg(8, 0, 50, 2, 0, 2, 52, 0);
    chk("t3_offset", longint'(offset), 60);
    // saturation high, then clear
    seg(8, 0, 50, 0, 0, 3, 40, 0);
    chk("sat_hi_off", longint'(offset), OMAX);
    chk("sat_hi_flag", longint'(sat), 1);
    clear = 1; cyc(); clear = 0;
    chk("clr_off", longint'(offset), 0);
    chk("clr_sat", longint'(sat), 0);
    seg(5, 1, 50, 0, 0, 4, 40, 0);
    chk("sat_lo_off", longint'(offset), OMIN);
    // enable dropped mid-NEG, then restart
    enable = 0; clear = 1; cyc(); clear = 0;
    seg(6, 0, 77, 1, 0, 2, 10, 0);
    enable = 0; cyc();
    chk("drop_mod", longint'(mod), 0);
    chk("drop_upd", longint'(upd_stb), 0);
    cyc();
    seg(6, 0, 77, 1, 0, 2, 20, 0);
    // lock: zero steps, then a bad step
    e_const = int'($urandom_range(0, 4000)) - 2000;
    seg(3, 0, 20, 0, 1, 0, 60, 0);
`ifdef DLI_LOCK_DETECT_EN
    chk("lock_on", longint'(locked), 1);
`else
    chk("lock_tied", longint'(locked), 0);
`endif
    seg(3, 0, 20, 0, 1, 1, 20, 0);
    // random segments with mid-period config churn, clears, drops
    for (int k = 0; k < 20; k++) begin
      if (k == 10) begin rst_n = 0; cyc(); rst_n = 1; end
      seg($urandom_range(0, 10), $urandom_range(0, 8),
          int'($urandom_range(0, 65534)) - 32767, $urandom_range(0, 6),
          $urandom_range(0, 3), $urandom_range(0, 2) == 0 ? 0 : 1, 100, 1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
